// File: rtl/npu_instgen_pkg.sv
// Shared types for the tiled CONV instruction generator:
// FSM states, latched command, emitted instruction, address helper.
package npu_instgen_pkg;

  localparam int ADDR_W_P  = 32;
  localparam int DATA_W_P  = 32;
  localparam int FRAM_AW_P = 12;
  localparam int KRAM_AW_P = 12;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    EXEC,
    DONE
  } state_e;

  typedef struct packed {
    logic [FRAM_AW_P-1:0] feature_addr;
    logic [KRAM_AW_P-1:0] kernel_addr;
    logic [DATA_W_P-1:0]  chout;
    logic [DATA_W_P-1:0]  chin;
    logic [DATA_W_P-1:0]  width;
    logic [DATA_W_P-1:0]  height;
    logic [7:0]           ksizeh;
    logic [7:0]           ksizew;
    logic                 has_bias;
    logic                 has_relu;
    logic [FRAM_AW_P-1:0] wb_addr;
    logic [DATA_W_P-1:0]  wb_ch_offset;
    logic                 last;
  } conv_inst_t;

  typedef struct packed {
    logic [FRAM_AW_P-1:0] fbase;
    logic [KRAM_AW_P-1:0] kbase;
    logic [KRAM_AW_P-1:0] ktw;
    logic [DATA_W_P-1:0]  fw;
    logic [DATA_W_P-1:0]  fh;
    logic [DATA_W_P-1:0]  chin;
    logic [DATA_W_P-1:0]  chout;
    logic [7:0]           ksh;
    logic [7:0]           ksw;
    logic [7:0]           sx;
    logic [7:0]           sy;
    logic                 bias;
    logic                 relu;
    logic [FRAM_AW_P-1:0] wbbase;
    logic [DATA_W_P-1:0]  ow;
    logic [DATA_W_P-1:0]  oh;
  } conv_cmd_t;

  // Byte address to word address; callers truncate to their BRAM width.
  function automatic logic [ADDR_W_P-1:0] byte2word(
    input logic [ADDR_W_P-1:0] a
  );
    return a >> 2;
  endfunction

endpackage

// File: rtl/conv_instgen_tiled_if.sv
// Registered instruction port between the CONV generator and the decoder.
// master drives the instruction bundle, slave returns decoder_ready.
interface conv_instgen_tiled_if #(
  parameter int DATA_W  = 32,
  parameter int FRAM_AW = 12,
  parameter int KRAM_AW = 12
);

  logic [FRAM_AW-1:0] inst_feature_addr;
  logic [KRAM_AW-1:0] inst_kernel_addr;
  logic [DATA_W-1:0]  inst_chout;
  logic [DATA_W-1:0]  inst_chin;
  logic [DATA_W-1:0]  inst_width;
  logic [DATA_W-1:0]  inst_height;
  logic [7:0]         inst_ksizeh;
  logic [7:0]         inst_ksizew;
  logic               inst_has_bias;
  logic               inst_has_relu;
  logic [FRAM_AW-1:0] inst_wb_addr;
  logic [DATA_W-1:0]  inst_wb_ch_offset;
  logic               inst_last;
  logic               inst_valid;
  logic               decoder_ready;

  modport master (
    output inst_feature_addr, inst_kernel_addr,
    output inst_chout, inst_chin, inst_width, inst_height,
    output inst_ksizeh, inst_ksizew,
    output inst_has_bias, inst_has_relu,
    output inst_wb_addr, inst_wb_ch_offset,
    output inst_last, inst_valid,
    input  decoder_ready
  );

  modport slave (
    input  inst_feature_addr, inst_kernel_addr,
    input  inst_chout, inst_chin, inst_width, inst_height,
    input  inst_ksizeh, inst_ksizew,
    input  inst_has_bias, inst_has_relu,
    input  inst_wb_addr, inst_wb_ch_offset,
    input  inst_last, inst_valid,
    output decoder_ready
  );

endinterface

// File: rtl/conv_instgen_cnt.sv
// Nested tile/ox/oy iteration counters, tile fastest then ox then oy.
// step advances one position; last flags the final (tile, ox, oy).
module conv_instgen_cnt #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [DATA_W-1:0] ntiles,
  input  logic [DATA_W-1:0] ow,
  input  logic [DATA_W-1:0] oh,
  output logic [DATA_W-1:0] tile,
  output logic [DATA_W-1:0] ox,
  output logic [DATA_W-1:0] oy,
  output logic              last
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] tile_q, tile_d;
  logic [DATA_W-1:0] ox_q, ox_d;
  logic [DATA_W-1:0] oy_q, oy_d;
  logic tile_end, ox_end, oy_end;

  assign tile_end = (tile_q == ntiles - ONE);
  assign ox_end   = (ox_q == ow - ONE);
  assign oy_end   = (oy_q == oh - ONE);
  assign last     = tile_end && ox_end && oy_end;

  always_comb begin
    tile_d = tile_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    if (clr) begin
      tile_d = '0;
      ox_d   = '0;
      oy_d   = '0;
    end else if (step) begin
      if (!tile_end) begin
        tile_d = tile_q + ONE;
      end else begin
        tile_d = '0;
        if (!ox_end) begin
          ox_d = ox_q + ONE;
        end else begin
          ox_d = '0;
          oy_d = oy_end ? '0 : oy_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_q <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
    end else begin
      tile_q <= tile_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
    end
  end

  assign tile = tile_q;
  assign ox   = ox_q;
  assign oy   = oy_q;

endmodule

// File: rtl/conv_instgen_tiled.sv
// Tiled CONV instruction generator: one instruction per (pixel, ch tile).
// INSTGEN_PERF_CNT_EN adds handshake and stall counters.
module conv_instgen_tiled
  import npu_instgen_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_P,
  parameter int DATA_W  = DATA_W_P,
  parameter int FRAM_AW = FRAM_AW_P,
  parameter int KRAM_AW = KRAM_AW_P,
  parameter int CH_TILE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  feature_baseaddr,
  input  logic [ADDR_W-1:0]  kernel_baseaddr,
  input  logic [KRAM_AW-1:0] kernel_tile_words,
  input  logic [DATA_W-1:0]  feature_width,
  input  logic [DATA_W-1:0]  feature_height,
  input  logic [DATA_W-1:0]  feature_chin,
  input  logic [DATA_W-1:0]  feature_chout,
  input  logic [7:0]         kernel_sizeh,
  input  logic [7:0]         kernel_sizew,
  input  logic [7:0]         stride_x,
  input  logic [7:0]         stride_y,
  input  logic               has_bias,
  input  logic               has_relu,
  input  logic [ADDR_W-1:0]  output_baseaddr,
  input  logic [DATA_W-1:0]  output_width,
  input  logic [DATA_W-1:0]  output_height,
  input  logic               csrcmd_valid,
  output logic               instgen_ready,
  conv_instgen_tiled_if.master inst_o,
`ifdef INSTGEN_PERF_CNT_EN
  output logic [DATA_W-1:0]  perf_inst_cnt,
  output logic [DATA_W-1:0]  perf_stall_cnt,
`endif
  output logic               compute_done
);

  localparam int TSH = $clog2(CH_TILE);
  localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);
  localparam logic [DATA_W-1:0] TMASK = DATA_W'(CH_TILE - 1);
  localparam logic [DATA_W-1:0] TILE  = DATA_W'(CH_TILE);

  state_e            state_q, state_d;
  conv_cmd_t         cmd_q, cmd_d;
  conv_inst_t        inst_q, inst_d, cur;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] plane_q, plane_d;
  logic [DATA_W-1:0] ntiles_q, ntiles_d;
  logic [DATA_W-1:0] lastch_q, lastch_d;
  logic [DATA_W-1:0] ntiles_c;
  logic [DATA_W-1:0] tile, ox, oy;
  logic              cnt_clr, cnt_step, cnt_last;
  logic              hs, zero_shape;

  assign hs = valid_q && inst_o.decoder_ready;

  assign ntiles_c = (cmd_q.chout >> TSH)
                  + ((|(cmd_q.chout & TMASK)) ? ONE : '0);

  assign zero_shape = (cmd_q.ow == '0) || (cmd_q.oh == '0)
                   || (cmd_q.chout == '0);

  conv_instgen_cnt #(
    .DATA_W (DATA_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .step   (cnt_step),
    .ntiles (ntiles_q),
    .ow     (cmd_q.ow),
    .oh     (cmd_q.oh),
    .tile   (tile),
    .ox     (ox),
    .oy     (oy),
    .last   (cnt_last)
  );

  // Instruction for the current counter position, all modulo field width.
  always_comb begin
    cur = '0;
    cur.feature_addr = cmd_q.fbase + FRAM_AW'(
      oy * DATA_W'(cmd_q.sy) * cmd_q.fw + ox * DATA_W'(cmd_q.sx));
    cur.kernel_addr  = cmd_q.kbase + KRAM_AW'(tile) * cmd_q.ktw;
    cur.chout        = (tile == ntiles_q - ONE) ? lastch_q : TILE;
    cur.chin         = cmd_q.chin;
    cur.width        = cmd_q.fw;
    cur.height       = cmd_q.fh;
    cur.ksizeh       = cmd_q.ksh;
    cur.ksizew       = cmd_q.ksw;
    cur.has_bias     = cmd_q.bias;
    cur.has_relu     = cmd_q.relu;
    cur.wb_addr      = cmd_q.wbbase + FRAM_AW'(
      ((tile << TSH) * plane_q) + oy * cmd_q.ow + ox);
    cur.wb_ch_offset = plane_q;
    cur.last         = cnt_last;
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    plane_d  = plane_q;
    ntiles_d = ntiles_q;
    lastch_d = lastch_q;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (csrcmd_valid) begin
          cmd_d.fbase  = FRAM_AW'(byte2word(feature_baseaddr));
          cmd_d.kbase  = KRAM_AW'(byte2word(kernel_baseaddr));
          cmd_d.ktw    = kernel_tile_words;
          cmd_d.fw     = feature_width;
          cmd_d.fh     = feature_height;
          cmd_d.chin   = feature_chin;
          cmd_d.chout  = feature_chout;
          cmd_d.ksh    = kernel_sizeh;
          cmd_d.ksw    = kernel_sizew;
          cmd_d.sx     = (stride_x == 8'd0) ? 8'd1 : stride_x;
          cmd_d.sy     = (stride_y == 8'd0) ? 8'd1 : stride_y;
          cmd_d.bias   = has_bias;
          cmd_d.relu   = has_relu;
          cmd_d.wbbase = FRAM_AW'(byte2word(output_baseaddr));
          cmd_d.ow     = output_width;
          cmd_d.oh     = output_height;
          state_d      = INIT;
        end
      end
      INIT: begin
        plane_d  = cmd_q.ow * cmd_q.oh;
        ntiles_d = ntiles_c;
        lastch_d = cmd_q.chout - ((ntiles_c - ONE) << TSH);
        cnt_clr  = 1'b1;
        state_d  = zero_shape ? DONE : EXEC;
      end
      EXEC: begin
        // Counters run one position ahead of the output register.
        if (hs && inst_q.last) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else if (!valid_q || inst_o.decoder_ready) begin
          inst_d   = cur;
          valid_d  = 1'b1;
          cnt_step = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      plane_q  <= '0;
      ntiles_q <= '0;
      lastch_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      plane_q  <= plane_d;
      ntiles_q <= ntiles_d;
      lastch_q <= lastch_d;
    end
  end

  assign instgen_ready = (state_q == IDLE);
  assign compute_done  = (state_q == DONE);

  assign inst_o.inst_feature_addr = inst_q.feature_addr;
  assign inst_o.inst_kernel_addr  = inst_q.kernel_addr;
  assign inst_o.inst_chout        = inst_q.chout;
  assign inst_o.inst_chin         = inst_q.chin;
  assign inst_o.inst_width        = inst_q.width;
  assign inst_o.inst_height       = inst_q.height;
  assign inst_o.inst_ksizeh       = inst_q.ksizeh;
  assign inst_o.inst_ksizew       = inst_q.ksizew;
  assign inst_o.inst_has_bias     = inst_q.has_bias;
  assign inst_o.inst_has_relu     = inst_q.has_relu;
  assign inst_o.inst_wb_addr      = inst_q.wb_addr;
  assign inst_o.inst_wb_ch_offset = inst_q.wb_ch_offset;
  assign inst_o.inst_last         = inst_q.last;
  assign inst_o.inst_valid        = valid_q;

`ifdef INSTGEN_PERF_CNT_EN
  logic [DATA_W-1:0] pinst_q, pinst_d;
  logic [DATA_W-1:0] pstall_q, pstall_d;

  always_comb begin
    pinst_d  = pinst_q;
    pstall_d = pstall_q;
    if (state_q == INIT) begin
      pinst_d  = '0;
      pstall_d = '0;
    end else if (state_q == EXEC) begin
      if (hs && !(&pinst_q))
        pinst_d = pinst_q + ONE;
      if (valid_q && !inst_o.decoder_ready && !(&pstall_q))
        pstall_d = pstall_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pinst_q  <= '0;
      pstall_q <= '0;
    end else begin
      pinst_q  <= pinst_d;
      pstall_q <= pstall_d;
    end
  end

  assign perf_inst_cnt  = pinst_q;
  assign perf_stall_cnt = pstall_q;
`endif

endmodule
